bit_counter_16bit: RTL and testbench
====================================

// Module: bit_counter_16bit
// PURPOSE
//  - Registered population counter: counts the '1' bits of a 16-bit input word.
//  - Result is presented one clock later.
//  - Leaf datapath block; drives downstream logic that needs a ones-count (weight) of a bus.
//  - Purely datapath: no handshake, no state machine.
// PARAMETERS
//  - WIDTH     16                  input word width; only 16 is required and verified.
//  - RESULT_W  $clog2(WIDTH+1)=5   localparam, result width. Must hold WIDTH itself (16 -> 5 bits).
// PORTS
//  - clk     in   1   single clock; all state updates on the rising edge.
//  - rst_n   in   1   reset, asynchronous assert, active-low.
//  - in      in   16  word to be counted; sampled every rising clk edge.
//  - result  out  5   number of '1' bits in the last sampled in; unsigned, range 0..16.
// BEHAVIOUR
//  - Clocking and reset:
//    - One clock (clk). Reset (rst_n) is asynchronous and active-low.
//    - rst_n low forces result = 5'd0 immediately, independent of clk.
//    - Release of rst_n is synchronised by the integrating level. The block holds 0 until the first rising edge after release.
//  - Latency: exactly 1 cycle.
//    - At rising edge N, result <= popcount(in sampled at edge N).
//    - Value is valid from just after edge N until edge N+1.
//    - No internal pipeline beyond this single output register.
//  - Throughput: one new word per cycle, back-to-back. No stall or enable. Output updates every cycle.
//  - Counting logic:
//    - Combinational adder tree from in to the output register.
//    - Four 4-bit nibble counts, 3 bits each, 0..4.
//    - Two pair sums, 4 bits each, 0..8.
//    - One final sum, 5 bits, 0..16.
//    - Every adder is sized so nothing truncates. Result 16 (all ones) must read 5'b10000, never wrap to 0.
//  - Input rules:
//    - X/Z on in is not permitted in normal operation. No X-masking logic.
//    - in changing between edges has no effect until the next edge.
//  - Boundary conditions:
//    - in = 0 -> 0. in = 16'hFFFF -> 16.
//    - Single set bit at position 0 or position 15 -> 1. Bit position must not matter.
//    - Reset asserted mid-stream: result clears to 0 asynchronously. The word sampled on that edge is discarded.
//    - Reset held across clk edges: result stays 0.
//  - No other outputs. No status flags.
// STRUCTURE
//  - Shared package (bit_counter_pkg):
//    - localparam WIDTH = 16.
//    - localparam RESULT_W = 5.
//    - typedef logic [RESULT_W-1:0] count_t.
//  - One sub-module: nibble_popcount.
//    - Pure combinational, in[3:0] -> cnt[2:0].
//    - Instantiated four times, on in[3:0], in[7:4], in[11:8], in[15:12].
//  - Top level holds:
//    - the two-level adder tree;
//    - the single always block with the async reset for the result register.
// TESTING
//  - Reset: rst_n=0 with in=16'hFFFF, clk toggling -> result=0 throughout. First edge after release -> 16.
//  - Extremes, one cycle each:
//    - in=16'h0000 -> 0
//    - in=16'hFFFF -> 16
//    - in=16'h8000 -> 1
//    - in=16'h0001 -> 1
//  - Patterns:
//    - 16'hAAAA -> 8
//    - 16'h5555 -> 8
//    - 16'hC3E1 -> 8
//    - 16'h0911 -> 4
//    - 16'hF2F6 -> 11
//  - Latency and throughput: drive the 9 words above back-to-back, one per edge.
//    - Each result appears exactly one edge after its input.
//    - No gaps, no stale values.
//  - Async reset mid-stream: assert rst_n between edges while result=11.
//    - result=0 before the next edge.
//    - Deassert and apply 16'h0911 -> 4 after the next edge.
//  - Random: 10k random words compared against a reference popcount model, with a 1-cycle delay.
//    - Also cover all 16 one-hot words and all 16 one-cold words: expect 1 and 15 respectively.

Source files
------------

// File: rtl/bit_counter_pkg.sv
// Shared types and sizes for the 16-bit population counter.
// Result width must be wide enough to hold WIDTH itself (16 -> 5 bits).
// Nibble count width must be wide enough to hold 4 (3 bits).
package bit_counter_pkg;

  localparam int WIDTH    = 16;
  localparam int RESULT_W = $clog2(WIDTH + 1);
  localparam int NIB_W    = 3;
  localparam int PAIR_W   = 4;

  typedef logic [RESULT_W-1:0] count_t;
  typedef logic [NIB_W-1:0]    nib_cnt_t;
  typedef logic [PAIR_W-1:0]   pair_cnt_t;

endpackage

// File: rtl/nibble_popcount.sv
// Ones-count of a 4-bit slice.
// Latency: combinational.
// Backpressure: none, this is a pure datapath leaf.
module nibble_popcount
  import bit_counter_pkg::*;
(
  input  logic [3:0] in,
  output nib_cnt_t   cnt
);

  // Zero-extend every bit to the count width so the 0..4 sum cannot truncate.
  always_comb begin
    cnt = {2'b00, in[0]} + {2'b00, in[1]} + {2'b00, in[2]} + {2'b00, in[3]};
  end

endmodule

// File: rtl/bit_counter_16bit.sv
// Registered population count of a 16-bit word.
// Latency: 1 cycle, from the sampling edge to the result register.
// Backpressure: none; a new word is accepted on every edge.
module bit_counter_16bit
  import bit_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output count_t           result
);

  nib_cnt_t  nib_cnt  [4];
  pair_cnt_t pair_sum [2];
  count_t    total;

  // One counter per nibble: in[3:0], in[7:4], in[11:8], in[15:12].
  for (genvar g = 0; g < 4; g++) begin : g_nib
    nibble_popcount u_nib (
      .in  (in[4*g +: 4]),
      .cnt (nib_cnt[g])
    );
  end

  // Two-level adder tree; each level widens by one bit so 16 reads 5'b10000.
  always_comb begin
    pair_sum[0] = {1'b0, nib_cnt[0]} + {1'b0, nib_cnt[1]};
    pair_sum[1] = {1'b0, nib_cnt[2]} + {1'b0, nib_cnt[3]};
    total       = {1'b0, pair_sum[0]} + {1'b0, pair_sum[1]};
  end

  // Single output register; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else begin
      result <= total;
    end
  end

endmodule

// File: tb/tb_bit_counter_16bit.sv
// Self-checking bench for bit_counter_16bit: expected counts are queued as
// words are driven and compared one edge later, when the result register
// has captured them.
module tb_bit_counter_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic [4:0]  result;

  int errors = 0;
  int checks = 0;

  int unsigned exp_q[$];

  bit_counter_16bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (din),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ones-count, bit by bit.
  function automatic int unsigned ref_count(input logic [15:0] w);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (w[i] === 1'b1) n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: result=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Drive one word just after an edge, wait for the next edge, then compare
  // the oldest queued expectation against the registered result.
  task automatic apply(input string tag, input logic [15:0] w);
    int unsigned exp;
    din = w;
    exp_q.push_back(ref_count(w));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty_queue"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, {27'd0, result}, exp);
    end
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] pat [9];
  string       pat_tag [9];

  initial begin
    pat[0] = 16'h0000; pat_tag[0] = "zero";
    pat[1] = 16'hFFFF; pat_tag[1] = "all_ones";
    pat[2] = 16'h8000; pat_tag[2] = "bit15";
    pat[3] = 16'h0001; pat_tag[3] = "bit0";
    pat[4] = 16'hAAAA; pat_tag[4] = "aaaa";
    pat[5] = 16'h5555; pat_tag[5] = "5555";
    pat[6] = 16'hC3E1; pat_tag[6] = "c3e1";
    pat[7] = 16'h0911; pat_tag[7] = "0911";
    pat[8] = 16'hF2F6; pat_tag[8] = "f2f6";

    // Reset held with all-ones on the input: result must stay 0 across edges.
    rst_n = 1'b0;
    din   = 16'hFFFF;
    #1;
    chk("reset_async", {27'd0, result}, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("reset_held", {27'd0, result}, 0);
    end

    // Release away from an edge; the first edge after release captures 16.
    rst_n = 1'b1;
    #2;
    chk("reset_release_hold", {27'd0, result}, 0);
    apply("first_after_reset", 16'hFFFF);

    // Extremes and patterns, back-to-back, one per edge.
    for (int i = 0; i < 9; i++) begin
      apply(pat_tag[i], pat[i]);
    end
    chk("f2f6_is_11", {27'd0, result}, 11);

    // Mid-stream async reset while result=11: clears before the next edge.
    din = 16'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_async", {27'd0, result}, 0);
    @(posedge clk);
    #1;
    chk("mid_reset_held", {27'd0, result}, 0);
    rst_n = 1'b1;
    #1;
    apply("after_mid_reset", 16'h0911);
    chk("after_mid_reset_is_4", {27'd0, result}, 4);

    // One-hot and one-cold words.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      w = 16'h0001 << i;
      apply($sformatf("onehot_%0d", i), w);
      chk($sformatf("onehot_%0d_is_1", i), {27'd0, result}, 1);
    end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      w = ~(16'h0001 << i);
      apply($sformatf("onecold_%0d", i), w);
      chk($sformatf("onecold_%0d_is_15", i), {27'd0, result}, 15);
    end

    // Random words against the reference model.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] r;
      r = $urandom_range(0, 32'h0000FFFF);
      apply("random", r[15:0]);
    end

    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
